// File: rtl/ahb3lite_cmd_master.sv
// ahb3lite_cmd_master: turns a valid/ready command stream into pipelined
// NONSEQ SINGLE AHB3-Lite transfers, one address phase (slot A) and one
// data phase (slot D) in flight, with one in-order response per command.
module ahb3lite_cmd_master #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  i_hclk,
  input  logic                  i_hreset,
  // command stream
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [1:0]            i_req_size,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  // response stream
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  // AHB master side
  output logic                  o_hsel,
  output logic [ADDR_WIDTH-1:0] o_haddr,
  output logic                  o_hwrite,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [3:0]            o_hprot,
  output logic [1:0]            o_htrans,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic [DATA_WIDTH-1:0] i_hrdata,
  input  logic                  i_hready,
  input  logic                  i_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Error-recovery sequencer. ST_ERR1 waits for the second ERROR cycle,
  // ST_CANCEL emits the response for a dropped address phase, ST_DRAIN is
  // the cycle in which the last error response is on the outputs.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR1,
    ST_CANCEL,
    ST_DRAIN
  } err_state_t;

  err_state_t r_state;
  err_state_t w_state_next;

  logic                  r_a_valid;
  logic [DATA_WIDTH-1:0] r_a_wdata;
  logic                  r_d_valid;
  logic                  r_d_write;
  logic                  r_cancel_pending;

  logic                  r_hsel;
  logic [ADDR_WIDTH-1:0] r_haddr;
  logic                  r_hwrite;
  logic [2:0]            r_hsize;
  logic [1:0]            r_htrans;
  logic [DATA_WIDTH-1:0] r_hwdata;

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_err_busy;
  logic                  w_err_first;
  logic                  w_accept;

  assign w_err_busy  = (r_state != ST_IDLE);
  // First ERROR cycle: slave stalls with HRESP high. No command may enter
  // here, even into an empty A slot, since it would sit behind a failing bus.
  assign w_err_first = ~i_hready & i_hresp;
  assign o_req_ready = ~i_hreset & ~w_err_busy & ~w_err_first & (~r_a_valid | i_hready);
  assign w_accept    = i_req_valid & o_req_ready;

  assign o_hsel      = r_hsel;
  assign o_haddr     = r_haddr;
  assign o_hwrite    = r_hwrite;
  assign o_hsize     = r_hsize;
  assign o_hburst    = 3'b000;
  assign o_hprot     = HPROT_VAL;
  assign o_htrans    = r_htrans;
  assign o_hwdata    = r_hwdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  // Error sequencer state register.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Error sequencer next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_err_first) w_state_next = ST_ERR1;
      ST_ERR1:   if (i_hready) w_state_next = r_cancel_pending ? ST_CANCEL : ST_DRAIN;
      ST_CANCEL: w_state_next = ST_DRAIN;
      ST_DRAIN:  w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Pipeline slots, registered bus outputs and response generation.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_a_valid        <= 1'b0;
      r_a_wdata        <= '0;
      r_d_valid        <= 1'b0;
      r_d_write        <= 1'b0;
      r_cancel_pending <= 1'b0;
      r_hsel           <= 1'b0;
      r_haddr          <= '0;
      r_hwrite         <= 1'b0;
      r_hsize          <= 3'd0;
      r_htrans         <= HTRANS_IDLE;
      r_hwdata         <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_rdata      <= '0;
      r_rsp_err        <= 1'b0;
    end else begin
      // Responses are single-cycle pulses.
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;

      // Data phase completes and the address phase advances on HREADY.
      if (i_hready) begin
        if (r_d_valid) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= i_hresp;
          r_rsp_rdata <= (~r_d_write & ~i_hresp) ? i_hrdata : '0;
        end
        r_d_valid <= r_a_valid;
        r_d_write <= r_hwrite;
        if (r_a_valid) begin
          r_hwdata <= r_a_wdata;
        end
      end

      // Response for the address phase that was dropped by an ERROR.
      if (r_state == ST_CANCEL) begin
        r_rsp_valid      <= 1'b1;
        r_rsp_err        <= 1'b1;
        r_rsp_rdata      <= '0;
        r_cancel_pending <= 1'b0;
      end

      // Address slot: load, empty, hold, or drop on the first ERROR cycle.
      if (w_accept) begin
        r_a_valid <= 1'b1;
        r_a_wdata <= i_req_wdata;
        r_hsel    <= 1'b1;
        r_htrans  <= HTRANS_NONSEQ;
        r_haddr   <= i_req_addr;
        r_hwrite  <= i_req_write;
        r_hsize   <= {1'b0, i_req_size};
      end else if (i_hready) begin
        r_a_valid <= 1'b0;
        r_hsel    <= 1'b0;
        r_htrans  <= HTRANS_IDLE;
      end else if ((r_state == ST_IDLE) && w_err_first) begin
        r_cancel_pending <= r_a_valid;
        r_a_valid        <= 1'b0;
        r_hsel           <= 1'b0;
        r_htrans         <= HTRANS_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Testbench for ahb3lite_cmd_master: behavioural SRAM slave with per-address
// wait/error injection, response scoreboard, per-cycle trace for timing checks.
module tb_ahb3lite_cmd_master;

  logic        clk = 1'b0;
  logic        hreset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        hsel, hwrite, hready, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  always #5 clk = ~clk;

  ahb3lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HPROT_VAL(4'b0011)) dut (
    .i_hclk(clk), .i_hreset(hreset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_size(req_size), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_hsel(hsel), .o_haddr(haddr), .o_hwrite(hwrite), .o_hsize(hsize),
    .o_hburst(hburst), .o_hprot(hprot), .o_htrans(htrans), .o_hwdata(hwdata),
    .i_hrdata(hrdata), .i_hready(hready), .i_hresp(hresp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [31:0] s_mem [16];
  int          wait_cfg [64];
  bit          err_cfg [64];
  bit          clear_mem_on_reset = 1'b1;
  logic        s_dp_valid = 1'b0, s_dp_write = 1'b0, s_dp_err = 1'b0, s_err_phase = 1'b0;
  logic [31:0] s_dp_addr = 32'h0;
  logic [1:0]  s_dp_size = 2'd0;
  int          s_wait_left = 0;

  function automatic bit lane_en(input logic [1:0] sz, input logic [1:0] a, input int b);
    case (sz)
      2'd0:    return (b == int'(a));
      2'd1:    return ((b / 2) == int'(a[1]));
      default: return 1'b1;
    endcase
  endfunction

  assign hready = !s_dp_valid ? 1'b1 : (s_dp_err ? s_err_phase : (s_wait_left == 0));
  assign hresp  = s_dp_valid & s_dp_err;
  // Garbage on error/write data phases so the DUT must zero rsp_rdata itself.
  assign hrdata = !s_dp_valid ? 32'h0 :
                  s_dp_err    ? 32'hBAD0BAD0 :
                  s_dp_write  ? 32'hCAFE0000 : s_mem[s_dp_addr[5:2]];

  always @(posedge clk) begin
    if (hreset) begin
      s_dp_valid  <= 1'b0;
      s_dp_err    <= 1'b0;
      s_err_phase <= 1'b0;
      s_wait_left <= 0;
      if (clear_mem_on_reset)
        for (int i = 0; i < 16; i++) s_mem[i] <= 32'h0;
    end else if (hready) begin
      if (s_dp_valid && s_dp_write && !s_dp_err)
        for (int b = 0; b < 4; b++)
          if (lane_en(s_dp_size, s_dp_addr[1:0], b))
            s_mem[s_dp_addr[5:2]][8*b +: 8] <= hwdata[8*b +: 8];
      s_dp_valid  <= hsel && (htrans == 2'b10);
      s_dp_addr   <= haddr;
      s_dp_write  <= hwrite;
      s_dp_size   <= hsize[1:0];
      s_dp_err    <= err_cfg[haddr[5:0]];
      s_wait_left <= wait_cfg[haddr[5:0]];
      s_err_phase <= 1'b0;
    end else if (s_dp_err) begin
      s_err_phase <= 1'b1;
    end else begin
      s_wait_left <= s_wait_left - 1;
    end
  end

  // ---------------- cycle counter and trace ----------------
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  tr_htrans [1024];
  logic [31:0] tr_haddr  [1024];
  logic [31:0] tr_hwdata [1024];
  logic        tr_ready  [1024];
  logic        tr_rspv   [1024];
  logic        tr_rspe   [1024];

  function automatic int ix(input int c);
    return (c < 0 || c > 1023) ? 0 : c;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          exp_cyc;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  always @(negedge clk) begin
    if (cyc < 1024) begin
      tr_htrans[cyc] <= htrans;
      tr_haddr[cyc]  <= haddr;
      tr_hwdata[cyc] <= hwdata;
      tr_ready[cyc]  <= req_ready;
      tr_rspv[cyc]   <= rsp_valid;
      tr_rspe[cyc]   <= rsp_err;
    end
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        if (mon_e.exp_cyc >= 0) check("rsp_latency_cycle", cyc, mon_e.exp_cyc);
        $display("[TB] rsp cycle %0d err=%0d rdata=0x%08h", cyc, rsp_err, rsp_rdata);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input bit w, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input bit push, input bit e,
                      input logic [31:0] rd, input bit chk_lat, output int acc);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = sz;
    req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        if (push) sb_q.push_back('{e, rd, chk_lat ? cyc + 3 : -1});
        $display("[TB] cmd cycle %0d %s addr=0x%08h size=%0d wdata=0x%08h", cyc, w ? "WR" : "RD", a, sz, wd);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no req_ready in 50 cycles, required acceptance (addr 0x%08h)", a);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [13];
  int   vacc [13];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    int a0, a1, a, b, c3, k, rel;

    vecs[0]  = '{1'b1, 32'h00, 2'd0, 32'h000000A1, 32'h0};
    vecs[1]  = '{1'b1, 32'h01, 2'd0, 32'h0000B200, 32'h0};
    vecs[2]  = '{1'b1, 32'h02, 2'd0, 32'h00C30000, 32'h0};
    vecs[3]  = '{1'b1, 32'h03, 2'd0, 32'hD4000000, 32'h0};
    vecs[4]  = '{1'b0, 32'h00, 2'd2, 32'h0,        32'hD4C3B2A1};
    vecs[5]  = '{1'b1, 32'h08, 2'd1, 32'h00005566, 32'h0};
    vecs[6]  = '{1'b1, 32'h0A, 2'd1, 32'h77880000, 32'h0};
    vecs[7]  = '{1'b0, 32'h08, 2'd2, 32'h0,        32'h77885566};
    vecs[8]  = '{1'b1, 32'h20, 2'd2, 32'h12345678, 32'h0};
    vecs[9]  = '{1'b0, 32'h20, 2'd2, 32'h0,        32'h12345678};
    vecs[10] = '{1'b0, 32'h10, 2'd2, 32'h0,        32'hDEADBEEF};
    vecs[11] = '{1'b1, 32'h24, 2'd2, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{1'b0, 32'h24, 2'd2, 32'h0,        32'hFFFFFFFF};
    for (int i = 0; i < 64; i++) begin
      wait_cfg[i] = 0;
      err_cfg[i]  = 1'b0;
    end

    // Reset held with a command offered.
    hreset    = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_size  = 2'd2;
    req_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_htrans", {30'b0, htrans}, 32'h0);
      check("reset_hsel", {31'b0, hsel}, 32'h0);
      check("reset_req_ready", {31'b0, req_ready}, 32'h0);
      check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    end
    check("reset_haddr", haddr, 32'h0);
    check("reset_hwdata", hwdata, 32'h0);
    check("reset_hwrite_hsize", {28'b0, hwrite, hsize}, 32'h0);
    check("hburst_hprot", {25'b0, hburst, hprot}, 32'h00000003);
    @(posedge clk); #1;
    hreset = 1'b0;
    rel = cyc;

    // Word write then read of 0x10, zero wait states.
    send(1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b1, a0);
    send(1'b0, 32'h10, 2'd2, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, a1);
    check("first_accept_at_release", a0, rel);
    check("read_accept_next_cycle", a1, a0 + 1);

    // Table vectors, back to back.
    for (int i = 0; i < 13; i++)
      send(vecs[i].w, vecs[i].addr, vecs[i].size, vecs[i].wdata, 1'b1, 1'b0,
           vecs[i].exp_rdata, 1'b1, vacc[i]);
    idle(8);
    check("write_nonseq_cycle", {30'b0, tr_htrans[ix(a0 + 1)]}, 32'h2);
    check("write_haddr", tr_haddr[ix(a0 + 1)], 32'h10);
    check("write_hwdata_dphase", tr_hwdata[ix(a0 + 2)], 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      check("byte_accept_throughput", vacc[i], vacc[0] + i);
      check("byte_htrans_nonseq", {30'b0, tr_htrans[ix(vacc[0] + 1 + i)]}, 32'h2);
      check("byte_haddr", tr_haddr[ix(vacc[0] + 1 + i)], i);
    end

    // Two wait states on the first of two reads.
    wait_cfg[6'h20] = 2;
    send(1'b0, 32'h20, 2'd2, 32'h0, 1'b1, 1'b0, 32'h12345678, 1'b0, a);
    send(1'b0, 32'h24, 2'd2, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, b);
    idle(10);
    wait_cfg[6'h20] = 0;
    check("wait_second_accept", b, a + 1);
    for (int j = 1; j <= 3; j++) begin
      check("wait_htrans_held", {30'b0, tr_htrans[ix(b + j)]}, 32'h2);
      check("wait_haddr_held", tr_haddr[ix(b + j)], 32'h24);
    end
    check("wait_ready_low1", {31'b0, tr_ready[ix(b + 1)]}, 32'h0);
    check("wait_ready_low2", {31'b0, tr_ready[ix(b + 2)]}, 32'h0);
    check("wait_ready_high", {31'b0, tr_ready[ix(b + 3)]}, 32'h1);
    check("wait_rsp_none_early", {31'b0, tr_rspv[ix(a + 4)]}, 32'h0);
    check("wait_rsp1_cycle", {31'b0, tr_rspv[ix(a + 5)]}, 32'h1);
    check("wait_rsp2_cycle", {31'b0, tr_rspv[ix(a + 6)]}, 32'h1);

    // Two-cycle ERROR on the first of two pipelined reads.
    err_cfg[6'h30] = 1'b1;
    send(1'b0, 32'h30, 2'd2, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, a);
    send(1'b0, 32'h10, 2'd2, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, b);
    send(1'b0, 32'h10, 2'd2, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, c3);
    idle(8);
    err_cfg[6'h30] = 1'b0;
    k = a + 2;
    check("err_second_accept", b, a + 1);
    check("err_htrans_first_cycle", {30'b0, tr_htrans[ix(k)]}, 32'h2);
    check("err_htrans_idle", {30'b0, tr_htrans[ix(k + 1)]}, 32'h0);
    for (int j = 0; j < 4; j++)
      check("err_ready_low", {31'b0, tr_ready[ix(k + j)]}, 32'h0);
    check("err_rsp1", {30'b0, tr_rspv[ix(k + 2)], tr_rspe[ix(k + 2)]}, 32'h3);
    check("err_rsp2", {30'b0, tr_rspv[ix(k + 3)], tr_rspe[ix(k + 3)]}, 32'h3);
    check("err_resume_accept", c3, k + 4);

    // Reset while a write sits in a stalled data phase.
    clear_mem_on_reset = 1'b0;
    wait_cfg[6'h38] = 6;
    send(1'b1, 32'h38, 2'd2, 32'h55AA55AA, 1'b0, 1'b0, 32'h0, 1'b0, a);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    hreset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_htrans", {30'b0, htrans}, 32'h0);
    check("midreset_hsel", {31'b0, hsel}, 32'h0);
    check("midreset_haddr", haddr, 32'h0);
    check("midreset_hwdata", hwdata, 32'h0);
    check("midreset_req_ready", {31'b0, req_ready}, 32'h0);
    check("midreset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    hreset = 1'b0;
    wait_cfg[6'h38] = 0;
    idle(10);
    send(1'b0, 32'h38, 2'd2, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, a);
    send(1'b0, 32'h10, 2'd2, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, b);
    idle(8);

    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
